// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/MEM register, doubleword data memory (ld/sd),
// branch resolution toward fetch and the registered MEM/WB bundle.
module mem_access_stage #(
  parameter int MEM_DEPTH = 512,
  parameter int ADDR_W    = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [63:0] ex_alu_result,
  input  logic        ex_zero,
  input  logic [63:0] ex_branch_tgt,
  input  logic [63:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_branch,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  input  logic [4:0]  ex_rd,
  input  logic        stall,
  input  logic        flush,
  output logic        pc_src,
  output logic [63:0] branch_target,
  output logic        misaligned,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_read_data
);

  logic        exm_valid;
  logic [63:0] exm_alu_result;
  logic        exm_zero;
  logic [63:0] exm_branch_tgt;
  logic [63:0] exm_store_data;
  logic        exm_mem_read;
  logic        exm_mem_write;
  logic        exm_branch;
  logic        exm_reg_write;
  logic        exm_mem_to_reg;
  logic [4:0]  exm_rd;

  logic [63:0]       mem [MEM_DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              q_mem_read;
  logic              q_mem_write;
  logic              q_reg_write;
  logic              q_mem_to_reg;
  logic              do_write;
  logic [63:0]       read_data;

  // Flush only kills the valid bit; the payload is irrelevant once invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      exm_valid      <= 1'b0;
      exm_alu_result <= '0;
      exm_zero       <= 1'b0;
      exm_branch_tgt <= '0;
      exm_store_data <= '0;
      exm_mem_read   <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_branch     <= 1'b0;
      exm_reg_write  <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      exm_rd         <= '0;
    end else if (flush) begin
      exm_valid <= 1'b0;
    end else if (!stall) begin
      exm_valid      <= ex_valid;
      exm_alu_result <= ex_alu_result;
      exm_zero       <= ex_zero;
      exm_branch_tgt <= ex_branch_tgt;
      exm_store_data <= ex_store_data;
      exm_mem_read   <= ex_mem_read;
      exm_mem_write  <= ex_mem_write;
      exm_branch     <= ex_branch;
      exm_reg_write  <= ex_reg_write;
      exm_mem_to_reg <= ex_mem_to_reg;
      exm_rd         <= ex_rd;
    end
  end

  always_comb begin
    q_mem_read    = exm_valid & exm_mem_read;
    q_mem_write   = exm_valid & exm_mem_write;
    q_reg_write   = exm_valid & exm_reg_write;
    q_mem_to_reg  = exm_valid & exm_mem_to_reg;
    idx           = exm_alu_result[ADDR_W+2:3];
    misaligned    = (q_mem_read | q_mem_write) & (exm_alu_result[2:0] != 3'd0);
    pc_src        = exm_valid & exm_branch & exm_zero;
    branch_target = exm_branch_tgt;
    do_write      = q_mem_write & !misaligned & !stall & !reset;
    read_data     = misaligned ? 64'h0 : mem[idx];
  end

  // Memory contents survive reset; a store sitting in EX/MEM at reset is dropped.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= exm_store_data;
    end
  end

  // A stall holds the EX/MEM instruction, so MEM/WB receives a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
      wb_alu_result <= '0;
      wb_read_data  <= '0;
    end else if (stall) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else begin
      wb_valid      <= exm_valid;
      wb_reg_write  <= q_reg_write & (exm_rd != 5'd0) & !(misaligned & q_mem_read);
      wb_mem_to_reg <= q_mem_to_reg;
      wb_rd         <= exm_rd;
      wb_alu_result <= exm_alu_result;
      wb_read_data  <= read_data;
    end
  end

endmodule
